// File: rtl/csi2_packet_builder.sv
// CSI-2 packet builder: AXI4-Stream pixel words in, FS / long-packet / FE bytes out, one byte per cycle.
// Define CSI2_TX_CRC_EN to compute the payload CRC-16; without it both CRC bytes are sent as zero.

module csi2_packet_builder #(
   parameter logic [1:0] VC_DEFAULT = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  vc,
   input  logic [5:0]  data_type,
   input  logic [15:0] wc,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [31:0] s_tdata,
   input  logic        s_tuser,
   input  logic        s_tlast,
   input  logic        frame_end,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        pkt_start,
   output logic        pkt_end,
   output logic        length_err,
   output logic        busy
);

   localparam int unsigned WC_W  = 16;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [2:0] {IDLE, FS_HDR, LP_HDR, PAYLOAD, CRC, FE_HDR} state_t;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        pos;
   logic              trunc;
   logic [31:0]       word_buf;
   logic [WC_W-1:0]   bytes_left;
   logic [1:0]        vc_q;
   logic [5:0]        dt_q;
   logic [WC_W-1:0]   wc_q;
   logic [WC_W-1:0]   frame_num;
   logic              fe_pend;
   logic [15:0]       crc_q;

   logic              fe_req, need_word, accept, emit_pay, last_pay;
   logic [7:0]        pay_byte, hdr_id, hdr_byte;
   logic [WC_W-1:0]   hdr_wc;
   logic [7:0]        nx_data;
   logic              nx_valid, nx_start, nx_end, nx_lerr;

   // 6-bit Hamming code over {WC, data_id}
   function automatic logic [5:0] ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   assign fe_req    = fe_pend | frame_end;
   assign need_word = (state == PAYLOAD) && (pos == 2'd0) && !trunc;
   assign s_tready  = need_word && !reset;
   assign accept    = need_word && s_tvalid;
   assign emit_pay  = (state == PAYLOAD) && ((pos != 2'd0) || trunc || s_tvalid);
   assign last_pay  = emit_pay && (bytes_left == WC_W'(1));

   // Byte 0 of a fresh word goes straight out; later bytes come from the buffer, zeros after truncation
   always_comb begin
      pay_byte = s_tdata[7:0];
      if (pos != 2'd0)
         pay_byte = word_buf[{pos, 3'b000} +: 8];
      else if (trunc)
         pay_byte = 8'h00;
   end

   always_comb begin
      hdr_id = {vc_q, dt_q};
      hdr_wc = wc_q;
      if (state == FS_HDR) begin
         hdr_id = {vc_q, 6'h00};
         hdr_wc = frame_num;
      end else if (state == FE_HDR) begin
         hdr_id = {vc_q, 6'h01};
         hdr_wc = frame_num;
      end
      case (idx[1:0])
         2'd0:    hdr_byte = hdr_id;
         2'd1:    hdr_byte = hdr_wc[7:0];
         2'd2:    hdr_byte = hdr_wc[15:8];
         default: hdr_byte = {2'b00, ecc6({hdr_wc, hdr_id})};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (fe_req)        state_nx = FE_HDR;
            else if (s_tvalid) state_nx = s_tuser ? FS_HDR : LP_HDR;
         end
         FS_HDR:  if (idx == IDX_W'(4)) state_nx = LP_HDR;
         LP_HDR:  if (idx == IDX_W'(3)) state_nx = PAYLOAD;
         PAYLOAD: if (last_pay)         state_nx = CRC;
         CRC:     if (idx == IDX_W'(1)) state_nx = IDLE;
         FE_HDR:  if (idx == IDX_W'(3)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      nx_data  = 8'h00;
      nx_valid = 1'b0;
      nx_start = 1'b0;
      nx_end   = 1'b0;
      nx_lerr  = 1'b0;
      case (state)
         FS_HDR, FE_HDR: begin
            // FS has a fifth, silent slot that separates it from the following line header
            nx_valid = (idx < IDX_W'(4));
            nx_data  = nx_valid ? hdr_byte : 8'h00;
            nx_start = (idx == IDX_W'(0));
            nx_end   = (idx == IDX_W'(3));
         end
         LP_HDR: begin
            nx_valid = 1'b1;
            nx_data  = hdr_byte;
            nx_start = (idx == IDX_W'(0));
         end
         PAYLOAD: begin
            nx_valid = emit_pay;
            nx_data  = emit_pay ? pay_byte : 8'h00;
            nx_lerr  = accept && (s_tlast ? (bytes_left > WC_W'(4)) : (bytes_left <= WC_W'(4)));
         end
         CRC: begin
            nx_valid = 1'b1;
            nx_data  = (idx == IDX_W'(0)) ? crc_q[7:0] : crc_q[15:8];
            nx_end   = (idx == IDX_W'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         pkt_start  <= 1'b0;
         pkt_end    <= 1'b0;
         length_err <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_out   <= nx_data;
         data_valid <= nx_valid;
         pkt_start  <= nx_start;
         pkt_end    <= nx_end;
         length_err <= nx_lerr;
         busy       <= (state_nx != IDLE);
      end
   end

   // Packet parameters are captured while idle, so they freeze at packet start
   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         pos        <= '0;
         trunc      <= 1'b0;
         word_buf   <= '0;
         bytes_left <= '0;
         vc_q       <= VC_DEFAULT;
         dt_q       <= '0;
         wc_q       <= '0;
         frame_num  <= WC_W'(1);
         fe_pend    <= 1'b0;
      end else begin
         idx <= (state_nx != state) ? IDX_W'(0) : idx + IDX_W'(1);
         if (state == IDLE && fe_req) fe_pend <= 1'b0;
         else if (frame_end)          fe_pend <= 1'b1;
         if (state == FE_HDR && idx == IDX_W'(3))
            frame_num <= (frame_num == {WC_W{1'b1}}) ? WC_W'(1) : frame_num + WC_W'(1);
         if (state == IDLE) begin
            vc_q       <= vc;
            dt_q       <= data_type;
            wc_q       <= wc;
            bytes_left <= wc;
            pos        <= 2'd0;
            trunc      <= 1'b0;
         end else if (state == PAYLOAD) begin
            if (emit_pay) begin
               bytes_left <= bytes_left - WC_W'(1);
               pos        <= (pos == 2'd0 && trunc) ? 2'd0 : pos + 2'd1;
            end
            if (accept) begin
               word_buf <= s_tdata;
               if (s_tlast && bytes_left > WC_W'(4)) trunc <= 1'b1;
            end
         end
      end
   end

`ifdef CSI2_TX_CRC_EN
   // Reflected CRC-16 (0x8408), init 0xFFFF, over emitted payload bytes
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
         else             r = r >> 1;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset || state == IDLE) crc_q <= 16'hFFFF;
      else if (emit_pay)          crc_q <= crc_upd(crc_q, pay_byte);
   end
`else
   assign crc_q = 16'h0000;
`endif

endmodule
